// File: rtl/pp_loader_pkg.sv
// Shared types and field layout for the framed state-loader stream.
// Header: [31:30] op, [29:28] target, [CNT_W-1:0] word count.
package pp_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_END   = 2'b01;

  localparam logic [1:0] TGT_IMEM = 2'b00;
  localparam logic [1:0] TGT_DMEM = 2'b01;
  localparam logic [1:0] TGT_RF   = 2'b10;

  localparam int OP_LSB  = 30;
  localparam int TGT_LSB = 28;

endpackage

// File: rtl/pp_loader_wr_reg.sv
// One-entry write holding register: loaded data appears on wr_* the edge it is accepted
// and is held unchanged until wr_ready; caller only loads when the slot is free or draining.
module pp_loader_wr_reg
  import pp_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [1:0]        ld_sel,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [31:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_sel  <= TGT_IMEM;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (load) begin
      wr_en   <= 1'b1;
      wr_sel  <= ld_sel;
      wr_addr <= ld_addr;
      wr_data <= ld_data;
    end else if (wr_ready) begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_state_loader.sv
// Framed stream to imem/dmem/regfile writer; data word accepted at edge k is on wr_* from k.
// s_ready drops while a write is pending in DATA, and for good once DONE or ERR is reached.
module pp_state_loader
  import pp_loader_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int RF_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [1:0]        wr_sel,
  output logic [31:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);

  loader_state_e    state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       tgt;
  logic [31:0]      addr;
  logic             end_pend;

  logic s_ready_c, acc, wr_done, pend_after;
  logic ld, supp, end_set;
  logic [1:0]  hdr_op, hdr_tgt;
  logic [33:0] rf_end;
  logic        tgt_mem;

  assign acc        = s_valid && s_ready;
  assign wr_done    = wr_en && wr_ready;
  assign pend_after = wr_en && !wr_ready;
  assign hdr_op     = s_data[OP_LSB +: 2];
  assign hdr_tgt    = s_data[TGT_LSB +: 2];
  assign tgt_mem    = (tgt == TGT_IMEM) || (tgt == TGT_DMEM);
  assign rf_end     = {2'b00, s_data[31:0]} + 34'(cnt);

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) state <= ST_HDR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready_c = 1'b0;
    ld        = 1'b0;
    supp      = 1'b0;
    end_set   = 1'b0;
    case (state)
      ST_HDR: begin
        s_ready_c = !end_pend;
        // END already taken: park here until the last write drains
        if (end_pend) begin
          if (!pend_after) state_nx = ST_DONE;
        end else if (acc) begin
          if (hdr_op == OP_WRITE && hdr_tgt != 2'b11) begin
            state_nx = ST_ADDR;
          end else if (hdr_op == OP_END) begin
            if (pend_after) end_set = 1'b1;
            else            state_nx = ST_DONE;
          end else begin
            state_nx = ST_ERR;
          end
        end
      end
      ST_ADDR: begin
        s_ready_c = 1'b1;
        if (acc) begin
          if (tgt_mem && s_data[1:0] != 2'b00)                state_nx = ST_ERR;
          else if (!tgt_mem && rf_end > 34'(RF_DEPTH))        state_nx = ST_ERR;
          else if (cnt == '0)                                 state_nx = ST_HDR;
          else                                                state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready_c = !wr_en || wr_ready;
        if (acc) begin
          supp = (tgt == TGT_RF) && (addr == '0);
          ld   = !supp;
          if (cnt == CNT_W'(1)) state_nx = ST_HDR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      cnt          <= '0;
      tgt          <= TGT_IMEM;
      addr         <= '0;
      end_pend     <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (acc && state == ST_HDR) begin
        tgt <= hdr_tgt;
        cnt <= s_data[CNT_W-1:0];
      end
      if (acc && state == ST_ADDR) addr <= s_data[31:0];
      if (acc && state == ST_DATA) begin
        addr <= addr + ((tgt == TGT_RF) ? 32'd1 : 32'd4);
        cnt  <= cnt - CNT_W'(1);
      end
      if (end_set) end_pend <= 1'b1;
      words_loaded <= words_loaded + CNT_W'(wr_done) + CNT_W'(supp);
    end
  end

  pp_loader_wr_reg #(.DATA_W(DATA_W)) u_wr_reg (
    .clk      (clk),
    .rst      (rstb),
    .load     (ld),
    .ld_sel   (tgt),
    .ld_addr  (addr),
    .ld_data  (s_data),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  assign s_ready   = s_ready_c && !rstb;
  assign core_hold = (state != ST_DONE);
  assign load_done = (state == ST_DONE);
  assign load_err  = (state == ST_ERR);

endmodule

// File: doc/pp_state_loader.md
# pp_state_loader

Hardware state loader for the pipelined processor: accepts a framed 32-bit word stream over a valid/ready handshake and writes it into instruction memory, data memory or the register file. Holds the core in stall (`core_hold`) until an END frame is accepted. Sits between the host/bench stimulus port and the write ports of the stage-1 instruction memory, stage-4 data cache and stage-2 register file. It is the input-side counterpart of the status-dump path.

## Interface
- `DATA_W`, 32, stream and write data width
- `CNT_W`, 16, width of the frame word count and of `words_loaded`
- `RF_DEPTH`, 32, number of register file entries
- `clk`  in  1  clock; all logic on rising edge
- `rstb`  in  1  reset, asynchronous, active-high (asserted = 1)
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader accepts word; a transfer happens when `s_valid && s_ready`
- `s_data`  in  DATA_W  stream word
- `wr_en`  out  1  write request, held until `wr_ready`
- `wr_ready`  in  1  target accepts write this cycle
- `wr_sel`  out  2  target: 0 = instr mem, 1 = data mem, 2 = register file
- `wr_addr`  out  32  byte address for memories, register index for register file
- `wr_data`  out  DATA_W  write data
- `core_hold`  out  1  core stall; high until load completes
- `load_done`  out  1  sticky, END accepted with no error
- `load_err`  out  1  sticky, malformed frame detected
- `words_loaded`  out  CNT_W  count of completed writes (wraps)

## Operation
- Header word: [31:30] op (00 block write, 01 END, 1x illegal). [29:28] target (11 illegal). [CNT_W-1:0] count N. Other bits ignored.
- Block write frame: header, then one start-address word, then N data words. N = 0 is legal: header + address, no writes.
- FSM states: HDR, ADDR, DATA, DONE, ERR.
  - HDR: accept word. op 00 with legal target -> ADDR. op 01 -> DONE. Anything else -> ERR.
  - ADDR: accept word and latch it as the address.
    - Memory target with addr[1:0] != 0 -> ERR.
    - Register target with addr + N > RF_DEPTH -> ERR.
    - Otherwise, N = 0 -> HDR and N > 0 -> DATA.
  - DATA: each accepted word becomes one write. Address steps +4 for memories and +1 for the register file. After the Nth word -> HDR.
  - DONE, ERR: terminal until reset; `s_ready` = 0.
- Register index 0 writes are suppressed: no `wr_en`, but the word is still consumed and counted in `words_loaded`.
- `core_hold` = 1 in all states except DONE.
- `load_done` = 1 only in DONE. `load_err` = 1 only in ERR.
- `words_loaded` increments on each completed write (`wr_en && wr_ready`) and on each suppressed x0 word. Wraps modulo 2^CNT_W.

## Timing
- Reset values:
  - `s_ready` = 0 during reset; HDR after reset.
  - `wr_en` = 0, `wr_sel` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `core_hold` = 1, `load_done` = 0, `load_err` = 0, `words_loaded` = 0.
- `s_ready` = 1 in HDR and ADDR.
- In DATA, `s_ready` = `!wr_en || wr_ready`. This gives back-to-back throughput of one word per cycle when `wr_ready` stays high.
- Write latency: a data word accepted at edge k appears on `wr_*` with `wr_en` = 1 from edge k until the edge where `wr_ready` = 1.
- `wr_*` are stable while `wr_en && !wr_ready`.
- A pending write issued from the last data word completes normally even though the FSM has moved to HDR.
- END accepted at edge k:
  - State reaches DONE only once no write is pending.
  - `core_hold` falls and `load_done` rises on the same edge.
- Error at edge k: `load_err` = 1 after edge k. A write that was already pending still completes.
- Reset mid-frame: all state clears asynchronously. A pending write is dropped with no handshake.

## Structure
- Package `pp_loader_pkg`: `loader_state_e` enum, op codes (`OP_WRITE`, `OP_END`), target codes (`TGT_IMEM`, `TGT_DMEM`, `TGT_RF`), header field positions.
- One sub-module, `pp_loader_wr_reg`: the one-entry write holding register that holds `wr_*` until `wr_ready`. The FSM lives in the top module.

## Test plan
- Memory frame, `wr_ready` = 1: header {00,01,N=3}, addr 0x10000000, data 0xA,0xB,0xC, END.
  - Required: writes to 0x10000000, 0x10000004 and 0x10000008, on consecutive cycles.
  - Required: `words_loaded` = 3, `load_done` = 1, `core_hold` = 0.
- Register frame {00,10,N=3}, addr 0, data 1,2,3.
  - Required: x0 suppressed; writes reg1 = 2, reg2 = 3; `words_loaded` = 3.
- Backpressure: `wr_ready` low for 4 cycles during an instruction-memory frame {00,00,N=2} at addr 0x00400000.
  - Required: `s_ready` = 0 while a write is pending; `wr_*` stable.
  - Required: both writes complete in order, with no loss.
- Errors, each from reset:
  - Header op 11 -> `load_err` = 1.
  - Memory address 0x10000002 -> `load_err` = 1.
  - Register addr 30 with N = 3 -> `load_err` = 1.
  - In all cases: no `wr_en` for that frame, `s_ready` = 0, `core_hold` = 1.
- N = 0 frame followed by END.
  - Required: no writes, `words_loaded` = 0, `load_done` = 1.
- Reset asserted mid-DATA with a write pending.
  - Required: `wr_en` = 0 and all outputs at reset values immediately (asynchronously).
  - Required: a fresh frame after release loads correctly.
